// File: rtl/shift_pipe_unit_pkg.sv
// Shared definitions for the pipelined barrel shifter:
// mode encodings, default width, illegal-mode check, level-to-stage map.
package shift_pipe_unit_pkg;

  localparam int SPU_WIDTH = 32;

  localparam logic [2:0] SHIFT_SLL = 3'b000;
  localparam logic [2:0] SHIFT_SRL = 3'b001;
  localparam logic [2:0] SHIFT_SRA = 3'b010;
  localparam logic [2:0] SHIFT_ROL = 3'b011;
  localparam logic [2:0] SHIFT_ROR = 3'b100;

  function automatic logic is_illegal(
    input logic [2:0] mode
  );
    return mode > SHIFT_ROR;
  endfunction

  // Level k lives in stage floor(k*stages/shw), so the first
  // level of stage i is ceil(i*shw/stages).
  function automatic int lvl_first(
    input int i,
    input int stages,
    input int shw
  );
    return (i * shw + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One register stage of the shifter: applies mux levels FIRST..FIRST+NLVL-1.
// Ports: clk/rst_n/flush, load enable, upstream bundle in, registered bundle out.
module shift_pipe_stage
  import shift_pipe_unit_pkg::*;
#(
  parameter int WIDTH = SPU_WIDTH,
  parameter int SHW   = $clog2(WIDTH),
  parameter int FIRST = 0,
  parameter int NLVL  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             vld_i,
  input  logic [2:0]       mode_i,
  input  logic [SHW-1:0]   s_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             vld_o,
  output logic [2:0]       mode_o,
  output logic [SHW-1:0]   s_o,
  output logic [WIDTH-1:0] d_o
);

  logic             vld_d, vld_q;
  logic [2:0]       mode_d, mode_q;
  logic [SHW-1:0]   s_d, s_q;
  logic [WIDTH-1:0] d_d, d_q;
  logic [WIDTH-1:0] res;

  always_comb begin
    res = d_i;
    for (int k = 0; k < NLVL; k++) begin
      if (s_i[FIRST + k]) begin
        case (mode_i)
          SHIFT_SLL: res = res << (1 << (FIRST + k));
          SHIFT_SRL: res = res >> (1 << (FIRST + k));
          SHIFT_SRA: res = $signed(res) >>> (1 << (FIRST + k));
          SHIFT_ROL: res = (res << (1 << (FIRST + k)))
                         | (res >> (WIDTH - (1 << (FIRST + k))));
          SHIFT_ROR: res = (res >> (1 << (FIRST + k)))
                         | (res << (WIDTH - (1 << (FIRST + k))));
          default:   res = res;
        endcase
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    mode_d = mode_q;
    s_d    = s_q;
    d_d    = d_q;
    if (load) begin
      vld_d  = vld_i;
      mode_d = mode_i;
      s_d    = s_i;
      d_d    = res;
    end
    if (flush) vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      mode_q <= '0;
      s_q    <= '0;
      d_q    <= '0;
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      s_q    <= s_d;
      d_q    <= d_d;
    end
  end

  assign vld_o  = vld_q;
  assign mode_o = mode_q;
  assign s_o    = s_q;
  assign d_o    = d_q;

endmodule

// File: rtl/shift_pipe_unit.sv
// Pipelined multi-mode barrel shifter with elastic valid/ready pipeline.
// Ports: CLK, RST(n), FLUSH, IN_* request side, OUT_* result side.
module shift_pipe_unit
  import shift_pipe_unit_pkg::*;
#(
  parameter int WIDTH  = SPU_WIDTH,
  parameter int STAGES = 2,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       IN_MODE,
  input  logic [WIDTH-1:0] IN_D,
  input  logic [SHW-1:0]   IN_S,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_Y,
  output logic             OUT_ZERO,
  output logic             OUT_ILLEGAL
);

  logic [STAGES-1:0] vq_w;
  logic [STAGES-1:0] load_w;
  logic [2:0]        mode_w [STAGES+1];
  logic [SHW-1:0]    s_w    [STAGES+1];
  logic [WIDTH-1:0]  d_w    [STAGES+1];
  logic              in_acc;
  logic              unused_s;

  assign IN_READY = load_w[0] & RST & ~FLUSH;
  assign in_acc   = IN_VALID & IN_READY;

  // Illegal requests enter as zero data; every level keeps zero.
  assign mode_w[0] = IN_MODE;
  assign s_w[0]    = IN_S;
  assign d_w[0]    = is_illegal(IN_MODE) ? '0 : IN_D;

  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    localparam int FIRST = lvl_first(i, STAGES, SHW);
    localparam int NLVL  = lvl_first(i + 1, STAGES, SHW) - FIRST;
    logic vin;

    // Stage i can load unless it and everything after it is full
    // and the consumer is stalling.
    assign load_w[i] = OUT_READY | ~&vq_w[STAGES-1:i];

    if (i == 0) begin : g_first
      assign vin = in_acc;
    end else begin : g_next
      assign vin = vq_w[i-1];
    end

    shift_pipe_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .FIRST (FIRST),
      .NLVL  (NLVL)
    ) u_stg (
      .clk    (CLK),
      .rst_n  (RST),
      .flush  (FLUSH),
      .load   (load_w[i]),
      .vld_i  (vin),
      .mode_i (mode_w[i]),
      .s_i    (s_w[i]),
      .d_i    (d_w[i]),
      .vld_o  (vq_w[i]),
      .mode_o (mode_w[i+1]),
      .s_o    (s_w[i+1]),
      .d_o    (d_w[i+1])
    );
  end

  assign unused_s    = ^s_w[STAGES];
  assign OUT_VALID   = vq_w[STAGES-1];
  assign OUT_Y       = d_w[STAGES];
  assign OUT_ZERO    = OUT_VALID & ~|d_w[STAGES];
  assign OUT_ILLEGAL = is_illegal(mode_w[STAGES]);

endmodule
